// File: rtl/seq_detect_pkg.sv
//------------------------------------------------------------------------------
// Module   : seq_detect_pkg
// Purpose  : Shared types and constants for the serial sequence detector.
//            Holds the controller state encoding, the default maximum
//            pattern length and the matching pattern-length field width.
// Contents : c_PAT_MAX_DEF  - default maximum pattern length in bits
//            c_LEN_W_DEF    - width of a length/fill field for that default
//            state_t        - IDLE / RUN / DONE controller states
//            len_width()    - length-field width for any pattern size
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seq_detect_pkg;

  localparam int c_PAT_MAX_DEF = 8;

  // A length field must hold the value PAT_MAX itself, hence the +1.
  localparam int c_LEN_W_DEF = $clog2(c_PAT_MAX_DEF) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int len_width(input int pat_max);
    return $clog2(pat_max) + 1;
  endfunction

endpackage : seq_detect_pkg

`default_nettype wire

// File: rtl/seq_match_core.sv
//------------------------------------------------------------------------------
// Module   : seq_match_core
// Purpose  : Serial history shift register, saturating fill counter and
//            length-masked pattern compare for the sequence detector.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            i_clear      - clear history and fill (start of a run)
//            i_shift      - accept i_bit this cycle
//            i_bit        - serial data bit
//            i_pattern    - stored pattern, bit 0 = most recent bit
//            i_len        - stored pattern length (1..PAT_MAX)
//            i_overlap    - 1 keeps fill on a match, 0 clears it
//            o_hit        - combinational: the bit being shifted completes
//                           a match
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int PAT_MAX = c_PAT_MAX_DEF,
  parameter int LEN_W   = len_width(PAT_MAX)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic               i_bit,
  input  logic [PAT_MAX-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  input  logic               i_overlap,
  output logic               o_hit
);

  localparam logic [LEN_W-1:0] c_FILL_MAX = LEN_W'(PAT_MAX);

  logic [PAT_MAX-1:0] r_hist;
  logic [PAT_MAX-1:0] w_hist_nxt;
  logic [PAT_MAX-1:0] w_mask;
  logic [LEN_W-1:0]   r_fill;
  logic [LEN_W-1:0]   w_fill_nxt;

  // New bit enters at bit 0; the oldest bit falls off the top.
  generate
    if (PAT_MAX > 1) begin : g_hist_wide
      assign w_hist_nxt = {r_hist[PAT_MAX-2:0], i_bit};
    end else begin : g_hist_one
      assign w_hist_nxt = i_bit;
    end
  endgenerate

  // Only the low i_len bits take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      w_mask[i] = (LEN_W'(i) < i_len);
    end
  end

  assign w_fill_nxt = (r_fill == c_FILL_MAX) ? r_fill : r_fill + LEN_W'(1);

  // Evaluated against the post-shift history and fill so that the bit
  // being sampled this cycle counts toward the match.
  assign o_hit = i_shift &&
                 (w_fill_nxt >= i_len) &&
                 ((w_hist_nxt & w_mask) == (i_pattern & w_mask));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= w_hist_nxt;
      // Non-overlapping mode: the next match needs a full set of fresh bits.
      if (o_hit && !i_overlap) begin
        r_fill <= '0;
      end else begin
        r_fill <= w_fill_nxt;
      end
    end
  end

endmodule : seq_match_core

`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
//------------------------------------------------------------------------------
// Module   : seq_detect_ctrl
// Purpose  : Configurable serial sequence detector with match counting.
//            A valid/ready config port loads pattern, length, overlap mode
//            and match target in IDLE; start runs detection until the
//            target number of matches is seen, then the block parks in DONE.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            cfg_valid     - config offer       cfg_ready  - high in IDLE
//            cfg_pattern   - pattern bits (bit 0 = most recent bit)
//            cfg_len       - pattern length, legal 1..PAT_MAX
//            cfg_overlap   - 1 = overlapping matches allowed
//            cfg_target    - match count for completion, legal >= 1
//            start, abort  - run request / return to IDLE
//            bit_valid, bit_in - serial data stream
//            match         - one-cycle pulse per detected match
//            match_count   - matches since start
//            busy, done    - in RUN / in DONE
//            err_cfg       - one-cycle pulse on a rejected config
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int PAT_MAX = c_PAT_MAX_DEF,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PAT_MAX-1:0]     cfg_pattern,
  input  logic [$clog2(PAT_MAX):0] cfg_len,
  input  logic                   cfg_overlap,
  input  logic [CNT_W-1:0]       cfg_target,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   bit_valid,
  input  logic                   bit_in,
  output logic                   match,
  output logic [CNT_W-1:0]       match_count,
  output logic                   busy,
  output logic                   done,
  output logic                   err_cfg
);

  localparam int c_LEN_W = $clog2(PAT_MAX) + 1;
  localparam logic [c_LEN_W-1:0] c_LEN_MAX = c_LEN_W'(PAT_MAX);

  state_t               r_state;
  logic                 r_cfg_loaded;
  logic [PAT_MAX-1:0]   r_pattern;
  logic [c_LEN_W-1:0]   r_len;
  logic                 r_overlap;
  logic [CNT_W-1:0]     r_target;
  logic [CNT_W-1:0]     r_count;
  logic                 r_match;
  logic                 r_err_cfg;

  logic                 w_cfg_xfer;
  logic                 w_cfg_legal;
  logic                 w_restart;
  logic                 w_shift;
  logic                 w_hit;
  logic [CNT_W-1:0]     w_count_inc;

  assign w_cfg_xfer  = cfg_valid && (r_state == ST_IDLE);
  assign w_cfg_legal = (cfg_len != '0) && (cfg_len <= c_LEN_MAX) &&
                       (cfg_target != '0);

  // A start that actually enters RUN; a config transfer in the same cycle
  // takes precedence, and abort overrides everything.
  assign w_restart = !abort && start &&
                     (((r_state == ST_IDLE) && !cfg_valid && r_cfg_loaded) ||
                      (r_state == ST_DONE));

  // Abort also blocks the shift so an aborted bit leaves no trace.
  assign w_shift = (r_state == ST_RUN) && bit_valid && !abort;

  assign w_count_inc = r_count + CNT_W'(1);

  seq_match_core #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (c_LEN_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_restart),
    .i_shift   (w_shift),
    .i_bit     (bit_in),
    .i_pattern (r_pattern),
    .i_len     (r_len),
    .i_overlap (r_overlap),
    .o_hit     (w_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cfg_loaded <= 1'b0;
      r_pattern    <= '0;
      r_len        <= '0;
      r_overlap    <= 1'b0;
      r_target     <= '0;
      r_count      <= '0;
      r_match      <= 1'b0;
      r_err_cfg    <= 1'b0;
    end else begin
      // Pulses default low and are raised only by their event below.
      r_match   <= 1'b0;
      r_err_cfg <= 1'b0;

      if (abort) begin
        // Stored config and match_count survive an abort.
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cfg_xfer) begin
              if (w_cfg_legal) begin
                r_pattern    <= cfg_pattern;
                r_len        <= cfg_len;
                r_overlap    <= cfg_overlap;
                r_target     <= cfg_target;
                r_cfg_loaded <= 1'b1;
              end else begin
                r_err_cfg <= 1'b1;
              end
            end else if (w_restart) begin
              r_state <= ST_RUN;
              r_count <= '0;
            end
          end

          ST_RUN: begin
            if (w_hit) begin
              r_match <= 1'b1;
              r_count <= w_count_inc;
              if (w_count_inc == r_target) begin
                r_state <= ST_DONE;
              end
            end
          end

          ST_DONE: begin
            if (w_restart) begin
              r_state <= ST_RUN;
              r_count <= '0;
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign cfg_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign match       = r_match;
  assign match_count = r_count;
  assign err_cfg     = r_err_cfg;

endmodule : seq_detect_ctrl

`default_nettype wire
